adder_ctrl: RTL and testbench
=============================

ADDER_CTRL -- requirements
Module: adder_ctrl

Interface
REQ-001 Parameter LAT, default 2, sets the cycles from dp_load assertion to valid dp_q for the selected adder.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  in  4 each  requester 0 operands.
REQ-006 req0_cin  in  1  requester 0 carry-in.
REQ-007 req0_ready  out  1  one-cycle grant pulse; operands accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_cin, req1_ready  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 dp_a, dp_b  out  4 each  operands driven to the adder datapath.
REQ-010 dp_cin  out  1  carry-in to the datapath.
REQ-011 dp_load  out  1  datapath register load strobe.
REQ-012 dp_sel  out  1  datapath select: 0 = ripple result into Q[4:0], 1 = lookahead result into Q[9:5].
REQ-013 dp_q  in  10  datapath register output.
REQ-014 rsp_valid  out  1  one-cycle response strobe; no backpressure.
REQ-015 rsp_id  out  1  requester that owns the response.
REQ-016 rsp_sum  out  5  ripple-adder result.
REQ-017 rsp_match  out  1  1 when the ripple result equals the lookahead result.
REQ-018 rsp_ok  out  1  1 when both results equal the golden value a+b+cin, computed at 5 bits.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE_R, WAIT_R, CAP_R, ISSUE_C, WAIT_C, CAP_C and RESP.
REQ-020 In IDLE, when any req valid is high, the block SHALL assert the winner's ready for one cycle, latch its operands and id, and go to ISSUE_R.
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; the pointer resets so requester 0 wins the first tie.
REQ-022 ISSUE_R: dp_load=1 and dp_sel=0 for exactly one cycle, then WAIT_R.
REQ-023 WAIT_R SHALL last exactly LAT cycles with dp_load=0 and dp_sel=0.
REQ-024 CAP_R SHALL capture dp_q[4:0] as the ripple result.
REQ-025 ISSUE_C, WAIT_C and CAP_C SHALL mirror REQ-022..024 with dp_sel=1 and capture dp_q[9:5].
REQ-026 RESP SHALL assert rsp_valid for one cycle with rsp_id, rsp_sum, rsp_match and rsp_ok, then return to IDLE.
REQ-027 dp_a, dp_b and dp_cin SHALL hold the latched operands stable from ISSUE_R through CAP_C, and SHALL be 0 in IDLE.
REQ-028 Latency: for a grant at cycle T, rsp_valid SHALL occur at cycle T+5+2*LAT (T+9 at the default LAT).
REQ-029 The earliest next grant SHALL be at T+6+2*LAT; requests arriving while busy are held by the requester, not queued.
REQ-030 Golden arithmetic SHALL be zero-extended 4-bit plus 4-bit plus cin, giving a 5-bit result with no overflow loss.
REQ-031 rsp_* outputs other than rsp_valid SHALL hold their last values until the next RESP.
REQ-032 A requester that drops valid in the grant cycle SHALL still be served, because the grant is decided on the sampled valid.

Reset
REQ-033 While rst is asserted, the FSM SHALL be in IDLE and all outputs SHALL be 0, asynchronously, including in the middle of an operation.
REQ-034 The arbitration pointer SHALL reset to favor requester 0, and captured results SHALL reset to 0.
REQ-035 An operation in flight at reset SHALL be abandoned with no response issued.

Structure
REQ-036 Package adder_ctrl_pkg SHALL hold the state enumeration, the default LAT, and the width constants (operand width 4, result width 5, dp_q width 10).
REQ-037 Round-robin selection SHALL live in the sub-module rr_arb2 (two requests, grant one-hot, pointer update on accept).

Verification
REQ-038 req0: a=4, b=5, cin=0, LAT=2 -> req0_ready at T, rsp at T+9 with rsp_id=0, rsp_sum=9, rsp_match=1, rsp_ok=1.
REQ-039 req1: a=15, b=15, cin=1 -> rsp_sum=31, rsp_match=1, rsp_ok=1; dp_sel=0 for 4 cycles then 1 for 4 cycles.
REQ-040 Both requesters valid continuously after reset -> grants go 0, 1, 0, 1; rsp_id alternates in the same order.
REQ-041 Bench datapath model corrupts Q[9:5] to 0 for 3+3+0 -> rsp_sum=6, rsp_match=0, rsp_ok=0.
REQ-042 rst pulsed during WAIT_C -> all outputs 0 immediately, no rsp_valid, and the next request is served normally with full latency.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared state encoding, widths and golden arithmetic for the adder controller.
// Pure declarations: no latency, no flow control.
package adder_ctrl_pkg;
    localparam int OP_W    = 4;
    localparam int RES_W   = 5;
    localparam int DQ_W    = 10;
    localparam int LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_R,
        WAIT_R,
        CAP_R,
        ISSUE_C,
        WAIT_C,
        CAP_C,
        RESP
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            cin;
    } opnd_t;

    function automatic logic [RES_W-1:0] golden_sum(input opnd_t op);
        return RES_W'(op.a) + RES_W'(op.b) + RES_W'(op.cin);
    endfunction
endpackage

// File: rtl/adder_ctrl_if.sv
// Requester, datapath and response signals of the adder controller.
// master = controller side, slave = requesters plus datapath.
interface adder_ctrl_if;
    import adder_ctrl_pkg::*;

    logic            req0_valid;
    logic [OP_W-1:0] req0_a;
    logic [OP_W-1:0] req0_b;
    logic            req0_cin;
    logic            req0_ready;

    logic            req1_valid;
    logic [OP_W-1:0] req1_a;
    logic [OP_W-1:0] req1_b;
    logic            req1_cin;
    logic            req1_ready;

    logic [OP_W-1:0] dp_a;
    logic [OP_W-1:0] dp_b;
    logic            dp_cin;
    logic            dp_load;
    logic            dp_sel;
    logic [DQ_W-1:0] dp_q;

    logic             rsp_valid;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_sum;
    logic             rsp_match;
    logic             rsp_ok;

    modport master (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  dp_q,
        output req0_ready, req1_ready,
        output dp_a, dp_b, dp_cin, dp_load, dp_sel,
        output rsp_valid, rsp_id, rsp_sum, rsp_match, rsp_ok
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output dp_q,
        input  req0_ready, req1_ready,
        input  dp_a, dp_b, dp_cin, dp_load, dp_sel,
        input  rsp_valid, rsp_id, rsp_sum, rsp_match, rsp_ok
    );
endinterface

// File: rtl/adder_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, tie priority flips away
// from the winner on accept; requesters hold their request until accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    // prio_q names the requester that wins the next tie
    always_comb begin
        prio_d = prio_q;
        if (accept_i && (gnt_o != 2'b00)) begin
            prio_d = ~gnt_o[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
endmodule

// File: rtl/adder_ctrl.sv
// Serialises requests onto a shared ripple/lookahead datapath and compares both results;
// response 5+2*LAT cycles after grant, requesters hold valid while busy, no response backpressure.
module adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    adder_ctrl_if.master bus
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t           state_q;
    logic [1:0]       rdy_q;
    opnd_t            op_q;
    logic             id_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RES_W-1:0] rip_q;

    logic [OP_W-1:0]  dp_a_q;
    logic [OP_W-1:0]  dp_b_q;
    logic             dp_cin_q;
    logic             dp_load_q;
    logic             dp_sel_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [RES_W-1:0] rsp_sum_q;
    logic             rsp_match_q;
    logic             rsp_ok_q;

    logic [1:0]       req_vld;
    logic [1:0]       gnt;
    logic             can_grant;
    logic             accept;
    opnd_t            op0;
    opnd_t            op1;
    logic [RES_W-1:0] cla_res;
    logic [RES_W-1:0] gold;

    assign req_vld = {bus.req1_valid, bus.req0_valid};
    assign op0     = {bus.req0_a, bus.req0_b, bus.req0_cin};
    assign op1     = {bus.req1_a, bus.req1_b, bus.req1_cin};
    assign cla_res = bus.dp_q[DQ_W-1:RES_W];
    assign gold    = golden_sum(op_q);

    // Grants are decided in a free IDLE cycle or in RESP, so back-to-back service has no bubble
    assign can_grant = (state_q == RESP) || ((state_q == IDLE) && (rdy_q == 2'b00));
    assign accept    = can_grant && (req_vld != 2'b00);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_vld),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 2'b00;
            op_q        <= '0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            rip_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_cin_q    <= 1'b0;
            dp_load_q   <= 1'b0;
            dp_sel_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_match_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
        end else begin
            rdy_q       <= 2'b00;
            dp_load_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                rdy_q <= gnt;
                id_q  <= gnt[1];
                op_q  <= gnt[1] ? op1 : op0;
            end
            // Outputs are registered on entry to the state in which they must appear
            case (state_q)
                IDLE: begin
                    if (rdy_q != 2'b00) begin
                        state_q   <= ISSUE_R;
                        dp_a_q    <= op_q.a;
                        dp_b_q    <= op_q.b;
                        dp_cin_q  <= op_q.cin;
                        dp_load_q <= 1'b1;
                        dp_sel_q  <= 1'b0;
                    end
                end
                ISSUE_R: begin
                    state_q <= WAIT_R;
                    cnt_q   <= CNT_W'(LAT - 1);
                end
                WAIT_R: begin
                    if (cnt_q == '0) state_q <= CAP_R;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                CAP_R: begin
                    rip_q     <= bus.dp_q[RES_W-1:0];
                    state_q   <= ISSUE_C;
                    dp_load_q <= 1'b1;
                    dp_sel_q  <= 1'b1;
                end
                ISSUE_C: begin
                    state_q <= WAIT_C;
                    cnt_q   <= CNT_W'(LAT - 1);
                end
                WAIT_C: begin
                    if (cnt_q == '0) state_q <= CAP_C;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                CAP_C: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_sum_q   <= rip_q;
                    rsp_match_q <= (rip_q == cla_res);
                    rsp_ok_q    <= (rip_q == gold) && (cla_res == gold);
                    dp_a_q      <= '0;
                    dp_b_q      <= '0;
                    dp_cin_q    <= 1'b0;
                    dp_sel_q    <= 1'b0;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = rdy_q[0];
    assign bus.req1_ready = rdy_q[1];
    assign bus.dp_a       = dp_a_q;
    assign bus.dp_b       = dp_b_q;
    assign bus.dp_cin     = dp_cin_q;
    assign bus.dp_load    = dp_load_q;
    assign bus.dp_sel     = dp_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_match  = rsp_match_q;
    assign bus.rsp_ok     = rsp_ok_q;
endmodule

// File: tb/tb_adder_ctrl.sv
// Bench for adder_ctrl: directed vector table, round-robin and mid-operation reset
// sequences, then random traffic against a transaction-level reference model.
module tb_adder_ctrl;
    import adder_ctrl_pkg::*;

    localparam int LAT     = LAT_DEF;
    localparam int RSP_LAT = 2 * LAT + 5;

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] sum;
        logic       match;
        logic       ok;
    } vec_t;

    typedef struct {
        int         cyc;
        logic       id;
        logic [4:0] sum;
        logic       match;
        logic       ok;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    adder_ctrl_if bus ();

    adder_ctrl #(.LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lookahead half of the datapath is faulty for 3+3+0, returning 0
    function automatic logic [4:0] lookahead_model(input logic [3:0] a, input logic [3:0] b, input logic cin);
        if (a == 4'd3 && b == 4'd3 && cin == 1'b0) return 5'd0;
        return 5'(a) + 5'(b) + 5'(cin);
    endfunction

    // Datapath model: result lands in dp_q exactly LAT edges after the load edge
    logic [9:0] dpq_r;
    logic       pv   [LAT];
    logic [4:0] pval [LAT];
    logic       psel [LAT];

    always @(posedge clk) begin
        if (rst) begin
            dpq_r <= '0;
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            if (pv[LAT-1]) begin
                if (psel[LAT-1]) dpq_r[9:5] <= pval[LAT-1];
                else             dpq_r[4:0] <= pval[LAT-1];
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i]   <= pv[i-1];
                pval[i] <= pval[i-1];
                psel[i] <= psel[i-1];
            end
            pv[0]   <= bus.dp_load;
            psel[0] <= bus.dp_sel;
            pval[0] <= bus.dp_sel ? lookahead_model(bus.dp_a, bus.dp_b, bus.dp_cin)
                                  : 5'(bus.dp_a) + 5'(bus.dp_b) + 5'(bus.dp_cin);
        end
    end
    assign bus.dp_q = dpq_r;

    function automatic logic [21:0] all_outs();
        return {bus.req0_ready, bus.req1_ready, bus.dp_a, bus.dp_b, bus.dp_cin, bus.dp_load,
                bus.dp_sel, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_match, bus.rsp_ok};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_req(input bit id, input bit v, input logic [3:0] a, input logic [3:0] b, input logic cin);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 chk("reset outputs async", 32'(all_outs()), 0);
        repeat (2) @(negedge clk);
        chk("reset outputs held", 32'(all_outs()), 0);
        rst = 1'b0;
    endtask

    // Valid is high for exactly one sampling edge, so it is already gone in the grant cycle
    task automatic run_vec(input vec_t v, input string tag);
        int                 t_gnt;
        int                 n_load;
        bit                 got;
        bit                 held;
        logic [2*LAT+3:0]   selpat;
        set_req(v.id, 1'b1, v.a, v.b, v.cin);
        @(posedge clk);
        #1 set_req(v.id, 1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        chk({tag, " grant"}, {bus.req1_ready, bus.req0_ready}, v.id ? 2 : 1);
        t_gnt = cyc; got = 0; n_load = 0; held = 1; selpat = '0;
        for (int k = 1; k <= RSP_LAT + 3 && !got; k++) begin
            @(negedge clk);
            if (k <= 2 * LAT + 4) begin
                selpat = {selpat[2*LAT+2:0], bus.dp_sel};
                n_load += int'(bus.dp_load);
                if ({bus.dp_a, bus.dp_b, bus.dp_cin} !== {v.a, v.b, v.cin}) held = 0;
            end
            if (bus.rsp_valid) begin
                got = 1;
                chk({tag, " latency"}, cyc - t_gnt, RSP_LAT);
                chk({tag, " rsp_id"}, bus.rsp_id, v.id);
                chk({tag, " rsp_sum"}, bus.rsp_sum, v.sum);
                chk({tag, " rsp_match"}, bus.rsp_match, v.match);
                chk({tag, " rsp_ok"}, bus.rsp_ok, v.ok);
            end
        end
        chk({tag, " rsp seen"}, got, 1);
        chk({tag, " dp_sel trace"}, selpat, (1 << (LAT + 2)) - 1);
        chk({tag, " dp_load pulses"}, n_load, 2);
        chk({tag, " dp operands held"}, held, 1);
        @(negedge clk);
        chk({tag, " rsp_valid one cycle"}, bus.rsp_valid, 0);
        chk({tag, " rsp fields hold"}, {bus.rsp_id, bus.rsp_sum, bus.rsp_match, bus.rsp_ok},
            {v.id, v.sum, v.match, v.ok});
        chk({tag, " dp idle zero"}, {bus.dp_a, bus.dp_b, bus.dp_cin, bus.dp_sel}, 0);
    endtask

    task automatic run_tie();
        int gid[$];
        int gcyc[$];
        int rid[$];
        int rsum[$];
        do_reset();
        set_req(0, 1'b1, 4'd1, 4'd2, 1'b0);
        set_req(1, 1'b1, 4'd7, 4'd8, 1'b1);
        for (int k = 0; k < 4 * (RSP_LAT + 2) + 20 && rid.size() < 4; k++) begin
            @(negedge clk);
            if (bus.req0_ready) begin gid.push_back(0); gcyc.push_back(cyc); end
            if (bus.req1_ready) begin gid.push_back(1); gcyc.push_back(cyc); end
            if (gid.size() >= 4) begin
                set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
                set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
            end
            if (bus.rsp_valid) begin rid.push_back(int'(bus.rsp_id)); rsum.push_back(int'(bus.rsp_sum)); end
        end
        chk("tie grant count", gid.size(), 4);
        chk("tie rsp count", rid.size(), 4);
        for (int i = 0; i < gid.size(); i++) chk($sformatf("tie grant %0d id", i), gid[i], i % 2);
        for (int i = 0; i < rid.size(); i++) begin
            chk($sformatf("tie rsp %0d id", i), rid[i], i % 2);
            chk($sformatf("tie rsp %0d sum", i), rsum[i], (i % 2 == 1) ? 16 : 3);
        end
        if (gcyc.size() >= 2) chk("tie grant spacing", gcyc[1] - gcyc[0], RSP_LAT + 1);
    endtask

    task automatic run_reset_mid();
        int   t_gnt;
        int   n_rsp;
        vec_t v;
        set_req(1, 1'b1, 4'd9, 4'd6, 1'b1);
        @(posedge clk);
        #1 set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        chk("rst-mid grant", bus.req1_ready, 1);
        t_gnt = cyc;
        while (cyc < t_gnt + LAT + 4) @(negedge clk);
        chk("rst-mid in WAIT_C", {bus.dp_sel, bus.dp_load, bus.dp_a}, {1'b1, 1'b0, 4'd9});
        #1 rst = 1'b1;
        #1 chk("rst-mid outputs cleared", 32'(all_outs()), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_rsp = 0;
        repeat (RSP_LAT + 4) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        chk("rst-mid no response", n_rsp, 0);
        v = '{1'b0, 4'd2, 4'd11, 1'b1, 5'd14, 1'b1, 1'b1};
        run_vec(v, "after-rst");
    endtask

    task automatic run_random(input int n_cyc);
        exp_t       q[$];
        exp_t       e;
        bit         v   [2];
        logic [3:0] ra  [2];
        logic [3:0] rb  [2];
        logic       rc  [2];
        bit         prefer;
        bit         have_last;
        bit         w;
        logic       wid;
        logic [1:0] rdy;
        logic [1:0] exp_rdy;
        logic [7:0] last_rsp;
        do_reset();
        prefer = 0; have_last = 0; last_rsp = '0;
        for (int r = 0; r < 2; r++) begin v[r] = 0; ra[r] = '0; rb[r] = '0; rc[r] = 1'b0; end
        for (int c = 0; c < n_cyc + 60; c++) begin
            @(negedge clk);
            rdy = {bus.req1_ready, bus.req0_ready};
            if (rdy != 2'b00) begin
                w       = (v[0] && v[1]) ? prefer : v[1];
                exp_rdy = (v[0] || v[1]) ? (w ? 2'b10 : 2'b01) : 2'b00;
                chk("rnd winner", rdy, exp_rdy);
                wid     = rdy[1];
                prefer  = !wid;
                e.cyc   = cyc + RSP_LAT;
                e.id    = wid;
                e.sum   = 5'(ra[wid]) + 5'(rb[wid]) + 5'(rc[wid]);
                e.match = (lookahead_model(ra[wid], rb[wid], rc[wid]) == e.sum);
                e.ok    = e.match;
                q.push_back(e);
                v[wid]  = 0;
            end
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rnd unexpected rsp", bus.rsp_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd rsp latency", cyc, e.cyc);
                    chk("rnd rsp fields", {bus.rsp_id, bus.rsp_sum, bus.rsp_match, bus.rsp_ok},
                        {e.id, e.sum, e.match, e.ok});
                    last_rsp  = {e.id, e.sum, e.match, e.ok};
                    have_last = 1;
                end
            end else if (have_last) begin
                chk("rnd rsp hold", {bus.rsp_id, bus.rsp_sum, bus.rsp_match, bus.rsp_ok}, last_rsp);
            end
            if (c < n_cyc) begin
                for (int r = 0; r < 2; r++) begin
                    if (!v[r] && $urandom_range(0, 2) == 0) begin
                        v[r] = 1;
                        if ($urandom_range(0, 7) == 0) begin
                            ra[r] = 4'd3; rb[r] = 4'd3; rc[r] = 1'b0;
                        end else begin
                            ra[r] = 4'($urandom); rb[r] = 4'($urandom); rc[r] = 1'($urandom);
                        end
                    end
                end
            end
            set_req(0, v[0], ra[0], rb[0], rc[0]);
            set_req(1, v[1], ra[1], rb[1], rc[1]);
        end
        chk("rnd queue drained", q.size(), 0);
        chk("rnd requests served", {v[0], v[1]}, 0);
        set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        vec_t vt[6];
        vt[0] = '{1'b0, 4'd4,  4'd5,  1'b0, 5'd9,  1'b1, 1'b1};
        vt[1] = '{1'b1, 4'd15, 4'd15, 1'b1, 5'd31, 1'b1, 1'b1};
        vt[2] = '{1'b0, 4'd3,  4'd3,  1'b0, 5'd6,  1'b0, 1'b0};
        vt[3] = '{1'b1, 4'd0,  4'd0,  1'b0, 5'd0,  1'b1, 1'b1};
        vt[4] = '{1'b0, 4'd8,  4'd7,  1'b1, 5'd16, 1'b1, 1'b1};
        vt[5] = '{1'b1, 4'd3,  4'd3,  1'b1, 5'd7,  1'b1, 1'b1};
        set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
        set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));
        run_tie();
        run_reset_mid();
        run_random(1500);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
